// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: instruction fields,
// opcode encodings and fetch FSM states.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W    = 28;
  localparam int unsigned OPC_HI     = 27;
  localparam int unsigned OPC_LO     = 24;
  localparam int unsigned OPERAND_HI = 23;
  localparam int unsigned OPERAND_LO = 0;
  localparam int unsigned JMP_TGT_HI = 23;
  localparam int unsigned JMP_TGT_LO = 16;
  localparam int unsigned CNT_W      = 24;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_STO = 4'h1,
    OP_LD  = 4'h2,
    OP_ADD = 4'h3,
    OP_BLE = 4'h8,
    OP_JMP = 4'h9
  } opcode_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } fetch_state_t;

  function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] word);
    return opcode_t'(word[OPC_HI:OPC_LO]);
  endfunction

endpackage

// File: rtl/instruction_fetch_nop_delay_counter.sv
// Down-counter that times NOP delays: load with N, decrement to zero.
module nop_delay_counter
  import instruction_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/instruction_fetch.sv
// Single-issue fetch stage: sequential PC, JMP/NOP handling in fetch,
// branch redirect from execute and downstream stall.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [ADDR_W-1:0]  oAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oValid,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oWaiting
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  opcode_t           opcode;
  logic [CNT_W-1:0]  operand;
  logic [ADDR_W-1:0] jmp_target;
  logic              cnt_clear;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              cnt_last;

  assign opcode     = opcode_of(iInstruction);
  assign operand    = iInstruction[OPERAND_HI:OPERAND_LO];
  assign jmp_target = ADDR_W'(iInstruction[JMP_TGT_HI:JMP_TGT_LO]);
  assign oAddress   = pc;

  // Counter controls follow the same priority as the FSM below.
  always_comb begin
    cnt_clear = iBranchTaken;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (!iBranchTaken && !iStall) begin
      if (state == ST_DELAY) begin
        cnt_dec = 1'b1;
      end else if ((opcode == OP_NOP) && (operand != '0)) begin
        cnt_load = 1'b1;
      end
    end
  end

  nop_delay_counter u_delay (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (operand),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_RUN;
      pc           <= RESET_ADDR;
      oInstruction <= '0;
      oValid       <= 1'b0;
      oPC          <= '0;
      oWaiting     <= 1'b0;
    end else if (iBranchTaken) begin
      state    <= ST_RUN;
      pc       <= iBranchTarget;
      oValid   <= 1'b0;
      oWaiting <= 1'b0;
    end else if (!iStall) begin
      case (state)
        ST_DELAY: begin
          oValid <= 1'b0;
          // Leave on the decrement that reaches zero: exactly N idle cycles.
          if (cnt_last || cnt_zero) begin
            state    <= ST_RUN;
            oWaiting <= 1'b0;
          end
        end
        ST_RUN: begin
          if (opcode == OP_JMP) begin
            pc     <= jmp_target;
            oValid <= 1'b0;
          end else if (opcode == OP_NOP) begin
            pc     <= pc + ADDR_W'(1);
            oValid <= 1'b0;
            if (operand != '0) begin
              state    <= ST_DELAY;
              oWaiting <= 1'b1;
            end
          end else begin
            oInstruction <= iInstruction;
            oPC          <= pc;
            oValid       <= 1'b1;
            pc           <= pc + ADDR_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: ROM model, issue scoreboard and
// direct output checks.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic        oValid;
  logic [15:0] oPC;
  logic        oWaiting;

  logic [27:0] rom [0:65535];
  logic [47:0] sb [$];
  logic        mon_hold;
  int          n_vec = 0;
  int          n_err = 0;

  instruction_fetch #(.ADDR_W(16), .RESET_ADDR(16'd0)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oAddress      (oAddress),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .oPC           (oPC),
    .oWaiting      (oWaiting)
  );

  assign iInstruction = rom[oAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] sto_word(input logic [15:0] a);
    return {OP_STO, 8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a);
    sb.push_back({4'h0, a, rom[a]});
  endtask

  task automatic do_reset();
    Reset         = 1'b1;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = '0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, 48'(sb.size()), 48'd0);
  endtask

  // Every real issue (oValid after an unstalled edge) must match the next expected word.
  always begin
    @(posedge Clock);
    mon_hold = iStall | iBranchTaken | Reset;
    #2;
    if (!mon_hold && oValid) begin
      if (sb.size() == 0) begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL issue_unexpected: observed pc=%0h instr=%0h expected no issue", oPC, oInstruction);
        end
      end else begin
        chk("issue", {4'h0, oPC, oInstruction}, sb.pop_front());
      end
    end
  end

  initial begin
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    for (int i = 0; i < 65536; i++) rom[i] = sto_word(16'(i));
    @(negedge Clock);
    chk("rst_addr", 48'(oAddress), 48'd0);
    chk("rst_valid", 48'(oValid), 48'd0);
    chk("rst_pc", 48'(oPC), 48'd0);
    chk("rst_instr", 48'(oInstruction), 48'd0);
    chk("rst_wait", 48'(oWaiting), 48'd0);

    // Sequential fetch after reset release
    do_reset();
    push(16'd0); push(16'd1); push(16'd2);
    chk("s1_addr0", 48'(oAddress), 48'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      chk("s1_addr", 48'(oAddress), 48'(i));
      chk("s1_pc", 48'(oPC), 48'(i - 1));
    end
    chk("s1_valid", 48'(oValid), 48'd1);
    chk_empty("s1_sb_empty");

    // NOP with N=0: one bubble only
    rom[0] = {OP_NOP, 24'd0};
    do_reset();
    push(16'd1);
    @(negedge Clock);
    chk("s7_valid", 48'(oValid), 48'd0);
    chk("s7_wait", 48'(oWaiting), 48'd0);
    chk("s7_addr", 48'(oAddress), 48'd1);
    @(negedge Clock);
    chk("s7_issue_pc", 48'(oPC), 48'd1);
    chk_empty("s7_sb_empty");
    rom[0] = sto_word(16'd0);

    // NOP delay of 3
    rom[0] = {OP_NOP, 24'd3};
    do_reset();
    push(16'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("s2_wait", 48'(oWaiting), 48'd1);
      chk("s2_valid", 48'(oValid), 48'd0);
      chk("s2_addr_held", 48'(oAddress), 48'd1);
    end
    @(negedge Clock);
    chk("s2_wait_done", 48'(oWaiting), 48'd0);
    chk("s2_valid_idle", 48'(oValid), 48'd0);
    @(negedge Clock);
    chk("s2_issue_valid", 48'(oValid), 48'd1);
    chk("s2_issue_pc", 48'(oPC), 48'd1);
    chk("s2_addr_next", 48'(oAddress), 48'd2);
    chk_empty("s2_sb_empty");
    rom[0] = sto_word(16'd0);

    // JMP at 14 to 13
    rom[14] = {OP_JMP, 8'd13, 16'h0000};
    do_reset();
    iBranchTaken = 1'b1; iBranchTarget = 16'd14;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    chk("s3_addr14", 48'(oAddress), 48'd14);
    chk("s3_squash", 48'(oValid), 48'd0);
    push(16'd13);
    @(negedge Clock);
    chk("s3_addr13", 48'(oAddress), 48'd13);
    chk("s3_jmp_valid", 48'(oValid), 48'd0);
    chk("s3_jmp_hidden", 48'(oInstruction), 48'd0);
    @(negedge Clock);
    chk("s3_issue_pc", 48'(oPC), 48'd13);
    chk("s3_addr_after", 48'(oAddress), 48'd14);
    chk_empty("s3_sb_empty");
    rom[14] = sto_word(16'd14);

    // Branch redirect while fetching address 10
    do_reset();
    iBranchTaken = 1'b1; iBranchTarget = 16'd7;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    push(16'd7); push(16'd8); push(16'd9);
    repeat (3) @(negedge Clock);
    chk("s4_addr10", 48'(oAddress), 48'd10);
    iBranchTaken = 1'b1; iBranchTarget = 16'd6;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    chk("s4_addr6", 48'(oAddress), 48'd6);
    chk("s4_squash", 48'(oValid), 48'd0);
    chk("s4_pc_kept", 48'(oPC), 48'd9);
    push(16'd6);
    @(negedge Clock);
    chk("s4_issue_pc", 48'(oPC), 48'd6);
    chk_empty("s4_sb_empty");

    // Two-cycle stall with oPC=8
    do_reset();
    iBranchTaken = 1'b1; iBranchTarget = 16'd8;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    push(16'd8);
    @(negedge Clock);
    chk("s5_pc8", 48'(oPC), 48'd8);
    iStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk("s5_addr_held", 48'(oAddress), 48'd9);
      chk("s5_pc_held", 48'(oPC), 48'd8);
      chk("s5_instr_held", 48'(oInstruction), 48'(sto_word(16'd8)));
      chk("s5_valid_held", 48'(oValid), 48'd1);
    end
    iStall = 1'b0;
    push(16'd9);
    @(negedge Clock);
    chk("s5_resume_pc", 48'(oPC), 48'd9);
    chk("s5_resume_addr", 48'(oAddress), 48'd10);
    chk_empty("s5_sb_empty");

    // Reset during a long NOP delay, then wrap at 16'hFFFF
    rom[0] = {OP_NOP, 24'd2000};
    do_reset();
    repeat (5) @(negedge Clock);
    chk("s6_waiting", 48'(oWaiting), 48'd1);
    chk("s6_addr1", 48'(oAddress), 48'd1);
    Reset = 1'b1;
    #1;
    chk("s6_rst_addr", 48'(oAddress), 48'd0);
    chk("s6_rst_wait", 48'(oWaiting), 48'd0);
    chk("s6_rst_valid", 48'(oValid), 48'd0);
    chk("s6_rst_pc", 48'(oPC), 48'd0);
    chk("s6_rst_instr", 48'(oInstruction), 48'd0);
    rom[0] = sto_word(16'd0);
    @(negedge Clock);
    Reset = 1'b0;
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    chk("s6_addr_ffff", 48'(oAddress), 48'hFFFF);
    chk("s6_no_residual_wait", 48'(oWaiting), 48'd0);
    push(16'hFFFF); push(16'h0000);
    @(negedge Clock);
    chk("s6_wrap_addr", 48'(oAddress), 48'd0);
    chk("s6_wrap_pc", 48'(oPC), 48'hFFFF);
    @(negedge Clock);
    chk("s6_after_wrap_pc", 48'(oPC), 48'd0);
    chk("s6_after_wrap_addr", 48'(oAddress), 48'd1);
    chk_empty("s6_sb_empty");

    Reset = 1'b1;
    @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 16'd0, address loaded into the PC on reset.
REQ-002 Parameter ADDR_W, default 16, PC and address width.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 iInstruction  in  28  instruction word from program ROM; combinational response to oAddress.
REQ-006 iStall  in  1  downstream not ready; freeze fetch.
REQ-007 iBranchTaken  in  1  execute stage resolved a taken branch (BLE) this cycle.
REQ-008 iBranchTarget  in  16  branch destination, valid with iBranchTaken.
REQ-009 oAddress  out  16  current PC, drives ROM iAddress.
REQ-010 oInstruction  out  28  registered instruction issued to decode.
REQ-011 oValid  out  1  oInstruction is a real issue this cycle.
REQ-012 oPC  out  16  address oInstruction was fetched from.
REQ-013 oWaiting  out  1  high while a NOP delay is counting.

Function
REQ-014 Opcode field SHALL be iInstruction[27:24]; NOP/JMP/BLE encodings SHALL come from the shared definitions header.
REQ-015 Latency: word at address A SHALL appear on oInstruction/oPC=A one cycle after oAddress=A.
REQ-016 FSM states SHALL be RUN and DELAY.
REQ-017 RUN, normal opcode, no stall: oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
REQ-018 PC increment SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-019 RUN, JMP fetched: PC<={8'b0, iInstruction[23:16]}, oValid<=0; JMP never issued downstream.
REQ-020 RUN, NOP fetched with operand N=iInstruction[23:0]: oValid<=0, PC<=PC+1; N=0 SHALL cost one bubble only; N>0 SHALL load counter with N and enter DELAY.
REQ-021 DELAY: counter decrements by 1 per cycle, oValid=0, oWaiting=1, PC held; on count reaching 0 return to RUN, fetch resumes next cycle (exactly N extra idle cycles).
REQ-022 iStall=1 (no branch): PC, oInstruction, oValid, oPC, state and counter SHALL all hold.
REQ-023 iBranchTaken=1: PC<=iBranchTarget, oValid<=0 (word fetched this cycle squashed), state<=RUN, counter<=0, regardless of iStall or DELAY.
REQ-024 Priority SHALL be Reset > iBranchTaken > iStall > JMP/NOP decode > sequential fetch.
REQ-025 Counter width SHALL be 24 bits; no saturation needed since it only decrements to 0.

Reset
REQ-026 On Reset assertion, asynchronously: PC/oAddress=RESET_ADDR, oInstruction=28'd0, oValid=0, oPC=0, oWaiting=0, state=RUN, counter=0.
REQ-027 First fetch SHALL occur on the first rising edge after Reset deasserts.
REQ-028 Reset mid-DELAY or mid-stall SHALL abandon the operation with no residual state.

Structure
REQ-029 Opcode constants, field bit positions and FSM state encodings SHALL live in the shared definitions header.
REQ-030 One sub-module nop_delay_counter (24-bit load/decrement/zero flag, async reset) SHALL be instantiated.

Verification
REQ-031 Reset release, ROM 0..3 sequential STO words -> oAddress 0,1,2,3 on successive cycles; oValid=1 with oPC 0,1,2 from second cycle on.
REQ-032 NOP 24'd3 at address 0, STO at 1 -> oValid=0 and oWaiting=1 for 3 cycles, then oAddress=1, STO issued with oPC=1 one cycle later.
REQ-033 JMP target 8'd13 at address 14 -> next oAddress=13, oValid=0 for that slot, JMP never seen on oInstruction.
REQ-034 iBranchTaken with iBranchTarget=6 while oAddress=10 -> next oAddress=6, word at 10 never issued (oValid=0).
REQ-035 iStall high 2 cycles while oPC=8 -> oAddress, oInstruction, oPC=8 held 2 cycles, then fetch resumes at 9 with no skipped or duplicated issue.
REQ-036 Reset pulsed during DELAY with counter=2000; PC forced to 16'hFFFF then run -> outputs reach reset values immediately; wrap case fetches 16'hFFFF then 16'h0000.
